cam_match_resolver: RTL
=======================

// Module: cam_match_resolver
// PURPOSE
//   Downstream of the CAM row array: consumes the CAM_DEPTH-bit vector of row_match flags from one search.
//   Resolves it into matching row addresses, lowest index first, as a valid/ready stream.
//   Reports hit/miss and the total match count per search.
//   Supports first-match-only and iterate-all-matches modes.
// PARAMETERS
//   CAM_DEPTH  8                          number of CAM rows (row_match_vec width), >= 2
//   ADDR_W     $clog2(CAM_DEPTH)          width of out_addr
//   CNT_W      $clog2(CAM_DEPTH+1)        width of match_count
// PORTS
//   clk            in   1          single clock, rising edge
//   rst            in   1          synchronous reset, active-high
//   in_valid       in   1          row_match_vec/mode_all carry a completed search
//   in_ready       out  1          resolver can accept a search
//   row_match_vec  in   CAM_DEPTH  bit i = row_match of row i
//   mode_all       in   1          1: emit every match; 0: emit lowest match only
//   out_valid      out  1          out_* beat is valid
//   out_ready      in   1          consumer accepts beat
//   out_addr       out  ADDR_W     matching row index (0 on miss)
//   out_hit        out  1          1 = beat carries a real match; 0 = miss beat
//   out_last       out  1          final beat of this search
//   match_count    out  CNT_W      popcount of captured vector, held until next capture
// BEHAVIOUR
//   Reset (rst=1 at clk edge):
//     - state=IDLE; pending vector, out_valid, out_addr, out_hit, out_last and match_count all 0.
//     - in_ready=1 from the first cycle after reset.
//     - rst mid-burst abandons remaining beats; no partial beat is left pending.
//   FSM states: IDLE, EMIT.
//     IDLE:
//       - in_ready=1, out_valid=0.
//       - On in_valid: register pend<=row_match_vec, mode<=mode_all, match_count<=popcount(vec); go EMIT.
//     EMIT:
//       - in_ready=0, out_valid=1.
//       - out_addr = index of lowest set bit of pend; out_hit = |pend.
//       - out_last = ~out_hit | ~mode | (pend has exactly one bit set).
//       - out_valid&out_ready & ~out_last: clear the emitted bit in pend; stay in EMIT.
//       - out_valid&out_ready & out_last: pend<=0; go IDLE.
//   Latency: capture edge -> first beat valid the next cycle. Beats then issue back-to-back at 1 per cycle while out_ready=1.
//   Throughput: one search per (beats+1) cycles. A bubble cycle in IDLE after the last beat is required.
//   Miss (vec==0): exactly one beat: out_hit=0, out_addr=0, out_last=1, match_count=0.
//   mode_all=0: exactly one beat, the lowest match, out_last=1. match_count is still the full popcount.
//   Backpressure: while out_valid=1 & out_ready=0, all out_* are held stable.
//   in_valid during EMIT is ignored (in_ready=0). The source holds in_valid until in_ready.
//   match_count saturates naturally: CNT_W holds CAM_DEPTH.
//   All outputs are registered or derived only from registered state; no in->out combinational path.
// STRUCTURE
//   Shared header cam_defs.vh:
//     - FSM state encodings (IDLE=1'b0, EMIT=1'b1).
//     - CAM_DEPTH default and clog2 helper, also used by the CAM array top.
//   Sub-module cam_prio_enc:
//     - Combinational lowest-set-bit encoder.
//     - Outputs idx[ADDR_W], any, onehot_mask (bit to clear), single (exactly one bit set).
//   Popcount is a local function in the resolver.
// TESTING (CAM_DEPTH=8)
//   1. vec=8'b0010_0100, mode_all=1, out_ready=1 -> beats {addr2,hit1,last0},{addr5,hit1,last1}; match_count=2; in_ready=1 after 3rd cycle.
//   2. vec=8'h00 -> single beat addr0,hit0,last1; match_count=0.
//   3. vec=8'hF0, mode_all=0 -> single beat addr4,hit1,last1; match_count=4; back to IDLE.
//   4. vec=8'h81, mode_all=1, out_ready low 3 cycles on beat 1 -> addr0 held stable 3 cycles, then addr7 last1.
//   5. vec=8'hFF, mode_all=1, rst=1 after 2 accepted beats -> next cycle out_valid=0, in_ready=1, match_count=0.
//   6. in_valid held high with vec=8'h80 then 8'h01 -> second search is captured only in IDLE after the last beat; addresses 7 then 0.

Source files
------------

// File: rtl/cam_match_resolver_pkg.sv
// Shared types and sizing helpers for the CAM match resolver and the CAM array top.
package cam_match_resolver_pkg;

  localparam int unsigned CAM_DEPTH_DEFAULT = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_t;

  // Address width that never collapses to zero bits.
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned w;
    w = $clog2(n);
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/cam_match_resolver_prio_enc.sv
// Combinational lowest-set-bit encoder over a row_match vector.
module cam_match_resolver_prio_enc
  import cam_match_resolver_pkg::*;
#(
  parameter int unsigned CAM_DEPTH = CAM_DEPTH_DEFAULT,
  parameter int unsigned ADDR_W    = clog2_min1(CAM_DEPTH)
) (
  input  logic [CAM_DEPTH-1:0] vec,
  output logic [ADDR_W-1:0]    idx,
  output logic                 any,
  output logic [CAM_DEPTH-1:0] onehot_mask,
  output logic                 single
);

  // Scan high to low so the lowest set bit is written last and wins.
  always_comb begin
    idx = '0;
    for (int i = int'(CAM_DEPTH) - 1; i >= 0; i--) begin
      if (vec[i]) idx = ADDR_W'(i);
    end
  end

  assign any         = |vec;
  assign onehot_mask = vec & (~vec + CAM_DEPTH'(1));
  assign single      = any & ~(|(vec & (vec - CAM_DEPTH'(1))));

endmodule

// File: rtl/cam_match_resolver.sv
// Resolves a CAM search's row_match vector into a lowest-first stream of row addresses.
module cam_match_resolver
  import cam_match_resolver_pkg::*;
#(
  parameter int unsigned CAM_DEPTH = CAM_DEPTH_DEFAULT,
  parameter int unsigned ADDR_W    = clog2_min1(CAM_DEPTH),
  parameter int unsigned CNT_W     = clog2_min1(CAM_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CAM_DEPTH-1:0] row_match_vec,
  input  logic                 mode_all,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ADDR_W-1:0]    out_addr,
  output logic                 out_hit,
  output logic                 out_last,
  output logic [CNT_W-1:0]     match_count
);

  function automatic logic [CNT_W-1:0] popcount(input logic [CAM_DEPTH-1:0] v);
    logic [CNT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < int'(CAM_DEPTH); i++) begin
      cnt = cnt + CNT_W'(v[i]);
    end
    return cnt;
  endfunction

  state_t               state, state_nxt;
  logic [CAM_DEPTH-1:0] pend, pend_nxt;
  logic [CAM_DEPTH-1:0] cur_mask, cur_mask_nxt;
  logic                 mode, mode_nxt;
  logic [CNT_W-1:0]     count_nxt;
  logic                 out_valid_nxt, in_ready_nxt;
  logic [ADDR_W-1:0]    out_addr_nxt;
  logic                 out_hit_nxt, out_last_nxt;

  logic [ADDR_W-1:0]    enc_idx;
  logic                 enc_any, enc_single;
  logic [CAM_DEPTH-1:0] enc_mask;

  // The encoder looks at next-cycle pending bits so every out_* field is registered.
  cam_match_resolver_prio_enc #(
    .CAM_DEPTH (CAM_DEPTH),
    .ADDR_W    (ADDR_W)
  ) u_prio_enc (
    .vec         (pend_nxt),
    .idx         (enc_idx),
    .any         (enc_any),
    .onehot_mask (enc_mask),
    .single      (enc_single)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      pend        <= '0;
      cur_mask    <= '0;
      mode        <= 1'b0;
      match_count <= '0;
      out_valid   <= 1'b0;
      in_ready    <= 1'b1;
      out_addr    <= '0;
      out_hit     <= 1'b0;
      out_last    <= 1'b0;
    end else begin
      state       <= state_nxt;
      pend        <= pend_nxt;
      cur_mask    <= cur_mask_nxt;
      mode        <= mode_nxt;
      match_count <= count_nxt;
      out_valid   <= out_valid_nxt;
      in_ready    <= in_ready_nxt;
      out_addr    <= out_addr_nxt;
      out_hit     <= out_hit_nxt;
      out_last    <= out_last_nxt;
    end
  end

  // Next state: capture in IDLE, retire one beat per accepted handshake in EMIT.
  always_comb begin
    state_nxt = state;
    pend_nxt  = pend;
    mode_nxt  = mode;
    count_nxt = match_count;
    unique case (state)
      ST_IDLE: begin
        if (in_valid) begin
          pend_nxt  = row_match_vec;
          mode_nxt  = mode_all;
          count_nxt = popcount(row_match_vec);
          state_nxt = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (out_ready) begin
          if (out_last) begin
            pend_nxt  = '0;
            state_nxt = ST_IDLE;
          end else begin
            pend_nxt = pend & ~cur_mask;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Beat fields for the cycle after this edge; zeroed whenever no beat will be presented.
  always_comb begin
    out_valid_nxt = 1'b0;
    in_ready_nxt  = 1'b1;
    out_addr_nxt  = '0;
    out_hit_nxt   = 1'b0;
    out_last_nxt  = 1'b0;
    cur_mask_nxt  = '0;
    if (state_nxt == ST_EMIT) begin
      out_valid_nxt = 1'b1;
      in_ready_nxt  = 1'b0;
      out_addr_nxt  = enc_idx;
      out_hit_nxt   = enc_any;
      out_last_nxt  = ~enc_any | ~mode_nxt | enc_single;
      cur_mask_nxt  = enc_mask;
    end
  end

endmodule
